// File: rtl/mult_pkg.sv
// Shared widths and state encoding for the 4-bit multiplier family and its MAC wrapper.
package mult_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/multiplier_4bits_version9.sv
// Combinational 4x4 unsigned multiplier built as a shift-and-add array.
module multiplier_4bits_version9
    import mult_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] product
);

    // Sum one shifted copy of a for every set bit of b.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        product = '0;
        for (int i = 0; i < OPND_W; i++) begin
            if (b[i]) begin
                product = product + (PROD_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mult4_mac_accumulator.sv
// Streaming MAC stage: registers operand pairs, multiplies them, and accumulates
// COUNT_N products into one result presented on a valid/ready output.
module mult4_mac_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int COUNT_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(COUNT_N + 1);
    localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(COUNT_N);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_N - 1);

    // Reject configurations the datapath cannot represent.
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("mult4_mac_accumulator: ACC_W must be >= 8");
    end
    if (COUNT_N < 1) begin : g_bad_count_n
        $error("mult4_mac_accumulator: COUNT_N must be >= 1");
    end

    mac_state_t        state;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  acc_cnt2;
    logic [ACC_W-1:0]  acc;
    logic              sticky_ovf;
    logic              s1_valid;
    logic [OPND_W-1:0] s1_a;
    logic [OPND_W-1:0] s1_b;
    logic [PROD_W-1:0] product;
    logic [ACC_W:0]    sum_next;
    logic              xfer;

    assign in_ready = (state == ACCUM) && (acc_cnt < COUNT_MAX);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != ACCUM) || (acc_cnt != '0);

    // Running sum with the carry out of ACC_W kept in the top bit.
    assign sum_next = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

    multiplier_4bits_version9 u_mult (
        .a       (s1_a),
        .b       (s1_b),
        .product (product)
    );

    // Stage-1 operand registers capture each accepted pair.
    // NOTE: pure data registers are not reset; s1_valid qualifies them, so their reset value is never used.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_a <= in_a;
            s1_b <= in_b;
        end
    end

    // Stage-1 valid flag marks a pair waiting to be accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= xfer;
        end
    end

    // Group control FSM, accumulator and registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            acc          <= '0;
            sticky_ovf   <= 1'b0;
            acc_cnt      <= '0;
            acc_cnt2     <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking updates; the group-close clears below deliberately override these increments.
            if (xfer) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (s1_valid) begin
                acc        <= sum_next[ACC_W-1:0];
                sticky_ovf <= sticky_ovf | sum_next[ACC_W];
                acc_cnt2   <= acc_cnt2 + 1'b1;
            end

            case (state)
                ACCUM: begin
                    if (xfer && (acc_cnt == COUNT_LAST)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s1_valid && (acc_cnt2 == COUNT_LAST)) begin
                        out_sum      <= sum_next[ACC_W-1:0];
                        out_overflow <= sticky_ovf | sum_next[ACC_W];
                        out_valid    <= 1'b1;
                        acc          <= '0;
                        sticky_ovf   <= 1'b0;
                        acc_cnt      <= '0;
                        acc_cnt2     <= '0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/mult4_mac_accumulator.md
Name: mult4_mac_accumulator

Overview:
Downstream consumer for the 4-bit multiplier family. It accepts operand pairs over a valid/ready handshake, registers them, and drives them into one combinational multiplier_4bits_version9 instance. It accumulates COUNT_N consecutive 8-bit products into an ACC_W-bit sum and presents each group result on a valid/ready output port. It is the sequential MAC wrapper that turns the combinational multiplier into a streaming dot-product stage.

Parameters:
ACC_W, 12, accumulator and result width; must be >= 8 (elaboration-time check).
COUNT_N, 4, number of products per result group; must be >= 1.
CNT_W, $clog2(COUNT_N+1), derived width of the group counters; not overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  stage can accept an operand pair.
in_a  input  4  multiplicand, unsigned.
in_b  input  4  multiplier, unsigned.
out_valid  output  1  group result valid.
out_ready  input  1  downstream accepts the result.
out_sum  output  ACC_W  sum of COUNT_N products, mod 2^ACC_W.
out_overflow  output  1  a carry out of ACC_W occurred within this group.
busy  output  1  high when any operand or partial sum is held (state != ACCUM, or acc_cnt != 0).

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, accumulator=0, sticky overflow=0, acc_cnt=0, acc_cnt2=0, s1_valid=0, out_valid=0, out_sum=0, out_overflow=0. in_ready=1 is available from the first edge after release.
- Input transfer: in_valid && in_ready at a rising edge. s1_a/s1_b <= in_a/in_b; s1_valid <= 1; acc_cnt++. Without a transfer, s1_valid <= 0.
- in_ready = (state==ACCUM) && (acc_cnt < COUNT_N). It is combinational from state only, never from in_valid.
- Stage 2 (accumulate): when s1_valid=1, {carry, acc} <= acc + zero-extended product; sticky overflow |= carry; acc_cnt2++.
- Latency: the Nth operand pair accepted at edge t yields out_valid=1 after edge t+1. Each product enters the sum exactly one edge after its acceptance.
- FSM:
  - ACCUM: accept operands. When the Nth transfer occurs, go to DRAIN.
  - DRAIN: in_ready=0. On the edge where the Nth product accumulates:
    - out_sum <= acc + product (final value).
    - out_overflow <= sticky overflow OR the final carry.
    - out_valid <= 1; go to HOLD.
    - acc, overflow, acc_cnt and acc_cnt2 all clear on that same edge.
  - HOLD: in_ready=0. out_sum, out_overflow and out_valid are held stable until out_ready=1. On out_valid && out_ready: out_valid <= 0, go to ACCUM. in_ready is high the following cycle.
- COUNT_N=1: ACCUM goes straight to DRAIN on the single transfer. Latency is unchanged.
- Input bubbles (in_valid low between transfers) only delay the result; the sum is unaffected.
- out_ready asserted while out_valid=0 has no effect.
- Arithmetic: products are unsigned 0..225. Accumulation is modulo 2^ACC_W; there is no saturation.
- Reset mid-group or mid-HOLD discards all partial and pending results immediately (async). A pending out_valid drops without a handshake.

Decomposition:
- Shared package mult_pkg:
  - OPND_W=4 and PROD_W=8 constants.
  - typedef enum {ACCUM, DRAIN, HOLD} mac_state_t.
- One sub-module: the existing multiplier_4bits_version9, instantiated once. It is fed from s1_a/s1_b, and its product feeds stage 2.
- No other hierarchy.

Test Plan:
- Basic group (defaults): send (2,3), (10,3), (13,10), (0,0) back-to-back with out_ready=1 -> out_sum=166, out_overflow=0; out_valid rises one edge after the 4th accept, for 1 cycle.
- Backpressure: same group, out_ready=0 for 5 cycles after out_valid -> out_sum stays 166, in_ready=0 throughout, out_valid stays high; release -> next cycle in_ready=1.
- Overflow (ACC_W=8): send (15,15), (15,15), (1,1), (0,0) -> out_sum=(450+1) mod 256=195, out_overflow=1; the next group (1,2)x4 -> out_sum=8, out_overflow=0.
- Bubbles, then back-to-back groups: in_valid toggles 1-0-1 across a group of (1,1), (2,2), (3,3), (4,4) -> out_sum=30. Follow with group (15,15)x4 -> out_sum=900. No cross-group leakage.
- Reset mid-operation: assert rst_n=0 after 2 accepted pairs -> all outputs 0 immediately, in_ready=1 after release. The next full group (5,5)x4 -> out_sum=100.
- COUNT_N=1: send (13,10) -> out_sum=130 one edge after accept; (0,7) -> out_sum=0.
